// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider, one quotient bit per clock.
// The controller pulses start with ACC as dividend and MDR as divisor. It stalls while
// busy is high and loads quotient into ACC on the one-cycle done pulse.
// Optional macro DIVIDER_SIGNED_EN: two's-complement operands. The core divides
// magnitudes, and the result signs are applied on the final step, so latency is
// unchanged.
// Handshake: start is sampled only in IDLE, and there is no back-pressure. busy is high
// for the WIDTH iteration cycles. done is high for exactly one cycle, when quotient,
// remainder and div_by_zero take their new values. Those outputs then hold until the
// next done or until reset.
module seq_divider #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t state, state_next;

  // Working registers: the dividend shift register also collects quotient bits from
  // the LSB end as the dividend bits leave at the MSB end.
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] prem_q;
  logic [CNT_W-1:0] cnt_q;

  // Operand values as captured at accept (magnitudes in the signed build).
  logic [WIDTH-1:0] dvd_in;
  logic [WIDTH-1:0] dvs_in;

  // One restoring step.
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             trial_ok;
  logic [WIDTH-1:0] step_quo;
  logic [WIDTH-1:0] step_rem;

  // Results written to the output registers on the final step.
  logic [WIDTH-1:0] fin_quo;
  logic [WIDTH-1:0] fin_rem;

`ifdef DIVIDER_SIGNED_EN
  logic q_neg_q;
  logic r_neg_q;

  // Capture magnitudes. 0x8000 maps onto itself, which is still the correct unsigned magnitude.
  assign dvd_in = dividend[WIDTH-1] ? -dividend : dividend;
  assign dvs_in = divisor[WIDTH-1]  ? -divisor  : divisor;
  // Restore the signs in the final-step cycle. Quotient sign follows the operand XOR;
  // remainder sign follows the dividend.
  assign fin_quo = q_neg_q ? -step_quo : step_quo;
  assign fin_rem = r_neg_q ? -step_rem : step_rem;
`else
  assign dvd_in  = dividend;
  assign dvs_in  = divisor;
  assign fin_quo = step_quo;
  assign fin_rem = step_rem;
`endif

  // Shift the next dividend bit into the partial remainder and try to subtract the
  // divisor. The result is kept one bit wider so its MSB acts as the borrow flag.
  always_comb begin
    shifted  = {prem_q, dvd_q[WIDTH-1]};
    trial    = shifted - {1'b0, dvs_q};
    trial_ok = ~trial[WIDTH];
    step_rem = trial_ok ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    step_quo = {dvd_q[WIDTH-2:0], trial_ok};
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic: a zero divisor skips RUN entirely
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) state_next = (divisor == '0) ? DONE : RUN;
      end
      RUN: begin
        if (cnt_q == '0) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Status outputs decoded from state
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: capture at accept, iterate in RUN, and update the visible results only on completion
  always_ff @(posedge clk) begin
    if (rst) begin
      dvd_q       <= '0;
      dvs_q       <= '0;
      prem_q      <= '0;
      cnt_q       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dvd_q  <= dvd_in;
            dvs_q  <= dvs_in;
            prem_q <= '0;
            cnt_q  <= CNT_W'(WIDTH - 1);
`ifdef DIVIDER_SIGNED_EN
            q_neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            r_neg_q <= dividend[WIDTH-1];
`endif
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end
          end
        end
        RUN: begin
          dvd_q  <= step_quo;
          prem_q <= step_rem;
          if (cnt_q == '0) begin
            quotient    <= fin_quo;
            remainder   <= fin_rem;
            div_by_zero <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
